// File: rtl/rpc2_ctrl_axi_wr_slot_scheduler_pkg.sv
// Shared constants for the AXI write slot scheduler: burst encoding and slot indices.
package rpc2_ctrl_axi_wr_slot_scheduler_pkg;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic       SLOT0           = 1'b0;
   localparam logic       SLOT1           = 1'b1;

endpackage

// File: rtl/rpc2_ctrl_slot_order_fifo.sv
// 1-bit wide order queue recording which write-data slot each accepted burst went to.
module rpc2_ctrl_slot_order_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push_i,
   input  logic din_i,
   input  logic pop_i,
   output logic dout_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign dout_o  = mem_q[rd_ptr_q];

   // Guard internally so the queue can never overflow or underflow.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din_i;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/rpc2_ctrl_axi_wr_slot_scheduler.sv
// Allocates accepted AW bursts to write-data slot 0/1, issues per-slot commands,
// tracks busy until done and records allocation order for the IP side.
module rpc2_ctrl_axi_wr_slot_scheduler
   import rpc2_ctrl_axi_wr_slot_scheduler_pkg::*;
#(
   parameter int C_AXI_ID_WIDTH          = 4,
   parameter int C_AXI_DATA_WIDTH        = 32,
   parameter int C_AXI_DATA_INTERLEAVING = 1,
   parameter int ORD_DEPTH               = 4,
   localparam int STRB_W                 = C_AXI_DATA_WIDTH / 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [C_AXI_ID_WIDTH-1:0] aw_id,
   input  logic [1:0]                aw_size,
   input  logic [1:0]                aw_burst,
   input  logic [STRB_W-1:0]         aw_strb,
   output logic                      wready0_req,
   output logic [1:0]                wready0_size,
   output logic                      wready0_fixed,
   output logic [STRB_W-1:0]         wready0_strb,
   output logic [C_AXI_ID_WIDTH-1:0] wready0_id,
   input  logic                      wready0_done,
   output logic                      wready1_req,
   output logic [1:0]                wready1_size,
   output logic                      wready1_fixed,
   output logic [STRB_W-1:0]         wready1_strb,
   output logic [C_AXI_ID_WIDTH-1:0] wready1_id,
   input  logic                      wready1_done,
   output logic                      ord_valid,
   output logic                      ord_slot,
   input  logic                      ord_pop,
   output logic [1:0]                slot_busy,
   output logic                      proto_err
);

   logic [1:0]                     busy_q, busy_d;
   logic                           last_q, last_d;
   logic [1:0]                     req_q, req_d;
   logic                           err_q, err_d;
   logic [1:0][1:0]                size_q, size_d;
   logic [1:0]                     fixed_q, fixed_d;
   logic [1:0][STRB_W-1:0]         strb_q, strb_d;
   logic [1:0][C_AXI_ID_WIDTH-1:0] id_q, id_d;

   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_head;
   logic       free_any;
   logic       mode_ok;
   logic       sel;
   logic       aw_hs;
   logic [1:0] done_w;

   assign done_w = {wready1_done, wready0_done};

   always_comb begin
      free_any = ~(busy_q[0] & busy_q[1]);
      if (C_AXI_DATA_INTERLEAVING == 0) begin
         mode_ok = (busy_q == 2'b00);
      end else begin
         // A burst may not share an ID with a burst still open in the other slot.
         mode_ok = ~(busy_q[0] & (aw_id == id_q[0])) & ~(busy_q[1] & (aw_id == id_q[1]));
      end
      sel      = (busy_q == 2'b00) ? ~last_q : (busy_q[0] ? SLOT1 : SLOT0);
      aw_ready = reset_n & free_any & ~fifo_full & mode_ok;
      aw_hs    = aw_valid & aw_ready;
   end

   always_comb begin
      busy_d  = busy_q;
      last_d  = last_q;
      req_d   = 2'b00;
      err_d   = err_q;
      size_d  = size_q;
      fixed_d = fixed_q;
      strb_d  = strb_q;
      id_d    = id_q;
      for (int s = 0; s < 2; s++) begin
         if (done_w[s]) begin
            if (busy_q[s]) busy_d[s] = 1'b0;
            else           err_d     = 1'b1;
         end
      end
      if (ord_pop && fifo_empty) err_d = 1'b1;
      if (aw_hs) begin
         busy_d[sel]  = 1'b1;
         req_d[sel]   = 1'b1;
         last_d       = sel;
         size_d[sel]  = aw_size;
         fixed_d[sel] = (aw_burst == AXI_BURST_FIXED);
         strb_d[sel]  = aw_strb;
         id_d[sel]    = aw_id;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q  <= 2'b00;
         last_q  <= SLOT1;
         req_q   <= 2'b00;
         err_q   <= 1'b0;
         size_q  <= '0;
         fixed_q <= '0;
         strb_q  <= '0;
         id_q    <= '0;
      end else begin
         busy_q  <= busy_d;
         last_q  <= last_d;
         req_q   <= req_d;
         err_q   <= err_d;
         size_q  <= size_d;
         fixed_q <= fixed_d;
         strb_q  <= strb_d;
         id_q    <= id_d;
      end
   end

   rpc2_ctrl_slot_order_fifo #(
      .DEPTH (ORD_DEPTH)
   ) u_order_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (aw_hs),
      .din_i   (sel),
      .pop_i   (ord_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign wready0_req   = req_q[0];
   assign wready0_size  = size_q[0];
   assign wready0_fixed = fixed_q[0];
   assign wready0_strb  = strb_q[0];
   assign wready0_id    = id_q[0];
   assign wready1_req   = req_q[1];
   assign wready1_size  = size_q[1];
   assign wready1_fixed = fixed_q[1];
   assign wready1_strb  = strb_q[1];
   assign wready1_id    = id_q[1];
   assign ord_valid     = ~fifo_empty;
   assign ord_slot      = fifo_head & ~fifo_empty;
   assign slot_busy     = busy_q;
   assign proto_err     = err_q;

endmodule

// File: tb/tb_rpc2_ctrl_axi_wr_slot_scheduler.sv
// Bench: two schedulers (interleaving on / off) share one directed stimulus and are
// compared every cycle against a queue-based behavioural model, plus literal checks.
module tb_rpc2_ctrl_axi_wr_slot_scheduler;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       aw_valid = 1'b0;
   logic [3:0] aw_id = '0;
   logic [1:0] aw_size = '0;
   logic [1:0] aw_burst = '0;
   logic [3:0] aw_strb = '0;
   logic       done0 = 1'b0;
   logic       done1 = 1'b0;
   logic       ord_pop = 1'b0;

   logic [1:0] awr, req0, req1, fx0, fx1, ov, os, perr;
   logic [1:0] sz0 [2];
   logic [1:0] sz1 [2];
   logic [3:0] sb0 [2];
   logic [3:0] sb1 [2];
   logic [3:0] id0 [2];
   logic [3:0] id1 [2];
   logic [1:0] busy [2];

   int passed = 0;
   int total = 0;

   always #5 clk = ~clk;

   // Instance 0 allows interleaving, instance 1 does not.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      rpc2_ctrl_axi_wr_slot_scheduler #(
         .C_AXI_ID_WIDTH          (4),
         .C_AXI_DATA_WIDTH        (32),
         .C_AXI_DATA_INTERLEAVING ((g == 0) ? 1 : 0),
         .ORD_DEPTH               (DEPTH)
      ) u_dut (
         .clk           (clk),
         .reset_n       (reset_n),
         .aw_valid      (aw_valid),
         .aw_ready      (awr[g]),
         .aw_id         (aw_id),
         .aw_size       (aw_size),
         .aw_burst      (aw_burst),
         .aw_strb       (aw_strb),
         .wready0_req   (req0[g]),
         .wready0_size  (sz0[g]),
         .wready0_fixed (fx0[g]),
         .wready0_strb  (sb0[g]),
         .wready0_id    (id0[g]),
         .wready0_done  (done0),
         .wready1_req   (req1[g]),
         .wready1_size  (sz1[g]),
         .wready1_fixed (fx1[g]),
         .wready1_strb  (sb1[g]),
         .wready1_id    (id1[g]),
         .wready1_done  (done1),
         .ord_valid     (ov[g]),
         .ord_slot      (os[g]),
         .ord_pop       (ord_pop),
         .slot_busy     (busy[g]),
         .proto_err     (perr[g])
      );
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: slot state per instance and the order queue as a ring of slot numbers.
   bit         m_busy  [2][2];
   bit         m_req   [2][2];
   bit         m_last  [2];
   bit         m_err   [2];
   logic [1:0] m_size  [2][2];
   bit         m_fixed [2][2];
   logic [3:0] m_strb  [2][2];
   logic [3:0] m_id    [2][2];
   int         m_q     [2][DEPTH];
   int         m_rd    [2];
   int         m_cnt   [2];

   function automatic void model_reset(int k);
      for (int s = 0; s < 2; s++) begin
         m_busy[k][s] = 0; m_req[k][s] = 0; m_size[k][s] = 0;
         m_fixed[k][s] = 0; m_strb[k][s] = 0; m_id[k][s] = 0;
      end
      m_last[k] = 1; m_err[k] = 0; m_rd[k] = 0; m_cnt[k] = 0;
   endfunction

   function automatic bit exp_ready(int k);
      if (!reset_n) return 0;
      if (m_busy[k][0] && m_busy[k][1]) return 0;
      if (m_cnt[k] >= DEPTH) return 0;
      if (k == 1 && (m_busy[k][0] || m_busy[k][1])) return 0;
      for (int s = 0; s < 2; s++)
         if (m_busy[k][s] && m_id[k][s] == aw_id) return 0;
      return 1;
   endfunction

   function automatic void model_step(int k);
      bit hs;
      int s;
      hs = aw_valid && exp_ready(k);
      s  = (!m_busy[k][0] && !m_busy[k][1]) ? 1 - int'(m_last[k]) : (m_busy[k][0] ? 1 : 0);
      m_req[k][0] = 0;
      m_req[k][1] = 0;
      if (done0) begin
         if (m_busy[k][0]) m_busy[k][0] = 0; else m_err[k] = 1;
      end
      if (done1) begin
         if (m_busy[k][1]) m_busy[k][1] = 0; else m_err[k] = 1;
      end
      if (ord_pop) begin
         if (m_cnt[k] == 0) m_err[k] = 1;
         else begin m_rd[k] = (m_rd[k] + 1) % DEPTH; m_cnt[k]--; end
      end
      if (hs) begin
         m_busy[k][s] = 1; m_req[k][s] = 1; m_last[k] = (s == 1);
         m_size[k][s] = aw_size; m_fixed[k][s] = (aw_burst == 2'b00);
         m_strb[k][s] = aw_strb; m_id[k][s] = aw_id;
         m_q[k][(m_rd[k] + m_cnt[k]) % DEPTH] = s;
         m_cnt[k]++;
      end
   endfunction

   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge clk or negedge reset_n);
         for (int k = 0; k < 2; k++) begin
            if (!reset_n) model_reset(k);
            else          model_step(k);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("i%0d.aw_ready", k), awr[k], exp_ready(k));
            check($sformatf("i%0d.busy", k), busy[k], {m_busy[k][1], m_busy[k][0]});
            check($sformatf("i%0d.req", k), {req1[k], req0[k]}, {m_req[k][1], m_req[k][0]});
            check($sformatf("i%0d.ord_valid", k), ov[k], m_cnt[k] != 0);
            check($sformatf("i%0d.ord_slot", k), os[k], (m_cnt[k] != 0) ? m_q[k][m_rd[k]] : 0);
            check($sformatf("i%0d.proto_err", k), perr[k], m_err[k]);
            check($sformatf("i%0d.size0", k), sz0[k], m_size[k][0]);
            check($sformatf("i%0d.fixed0", k), fx0[k], m_fixed[k][0]);
            check($sformatf("i%0d.strb0", k), sb0[k], m_strb[k][0]);
            check($sformatf("i%0d.id0", k), id0[k], m_id[k][0]);
            check($sformatf("i%0d.size1", k), sz1[k], m_size[k][1]);
            check($sformatf("i%0d.fixed1", k), fx1[k], m_fixed[k][1]);
            check($sformatf("i%0d.strb1", k), sb1[k], m_strb[k][1]);
            check($sformatf("i%0d.id1", k), id1[k], m_id[k][1]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // All driver tasks start and end 1 time unit after a rising edge.
   task automatic step(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step(2);
      reset_n = 1'b1;
   endtask

   task automatic aw_send(int k, logic [3:0] id, logic [1:0] sz, logic [1:0] bt, logic [3:0] sb);
      int w;
      aw_id = id; aw_size = sz; aw_burst = bt; aw_strb = sb; aw_valid = 1'b1;
      #1;
      w = 0;
      while (!awr[k] && w < 50) begin step(1); #1; w++; end
      if (!awr[k]) check("aw_wait_timeout", awr[k], 1);
      step(1);
      aw_valid = 1'b0;
   endtask

   task automatic pulse_done(logic d0, logic d1);
      done0 = d0; done1 = d1;
      step(1);
      done0 = 1'b0; done1 = 1'b0;
   endtask

   task automatic pulse_pop();
      ord_pop = 1'b1;
      step(1);
      ord_pop = 1'b0;
   endtask

   initial begin
      #1;
      reset_n = 1'b0;
      #1;
      check("rst.aw_ready", awr, 2'b00);
      step(2);
      reset_n = 1'b1;
      check("rst.busy", busy[0], 2'b00);
      check("rst.ord_valid", ov, 2'b00);

      // 1: single INCR burst
      aw_send(0, 4'd3, 2'd2, 2'b01, 4'hF);
      check("t1.req0", req0[0], 1);
      check("t1.id0", id0[0], 3);
      check("t1.size0", sz0[0], 2);
      check("t1.fixed0", fx0[0], 0);
      check("t1.ord_slot", os[0], 0);
      check("t1.ord_valid", ov[0], 1);
      check("t1.busy", busy[0], 2'b01);
      step(1);
      check("t1.req0_pulse", req0[0], 0);
      pulse_done(1'b1, 1'b0);
      check("t1.busy_done", busy[0], 2'b00);
      check("t1.strb_held", sb0[0], 4'hF);
      pulse_pop();
      check("t1.ord_empty", ov[0], 0);

      // 2: two IDs fill both slots, third burst stalls until a done
      do_reset();
      aw_send(0, 4'd1, 2'd2, 2'b01, 4'hF);
      aw_send(0, 4'd2, 2'd2, 2'b01, 4'hF);
      check("t2.busy_il", busy[0], 2'b11);
      check("t2.busy_noil", busy[1], 2'b01);
      check("t2.head", os[0], 0);
      aw_id = 4'd7; aw_valid = 1'b1;
      step(3);
      check("t2.stall", awr[0], 0);
      pulse_done(1'b1, 1'b0);
      aw_send(0, 4'd7, 2'd1, 2'b01, 4'h3);
      check("t2.busy_refill", busy[0], 2'b11);
      pulse_pop();
      check("t2.head_after_pop", os[0], 1);

      // 3: same-ID burst waits for retirement, then round-robin to slot 1
      do_reset();
      aw_send(0, 4'd5, 2'd1, 2'b01, 4'h3);
      aw_id = 4'd5; aw_valid = 1'b1;
      step(3);
      check("t3.same_id_stall", awr[0], 0);
      pulse_done(1'b1, 1'b0);
      aw_send(0, 4'd5, 2'd1, 2'b00, 4'h1);
      check("t3.busy", busy[0], 2'b10);
      check("t3.req1", req1[0], 1);
      check("t3.req0", req0[0], 0);
      check("t3.fixed1", fx1[0], 1);
      check("t3.id1", id1[0], 5);

      // 4: no interleaving, second burst held until the cycle after done0
      do_reset();
      aw_send(1, 4'd1, 2'd2, 2'b01, 4'hF);
      aw_id = 4'd2; aw_valid = 1'b1;
      #1;
      check("t4.held", awr[1], 0);
      step(2);
      done0 = 1'b1;
      #1;
      check("t4.done_cycle", awr[1], 0);
      step(1);
      done0 = 1'b0;
      #1;
      check("t4.after_done", awr[1], 1);
      aw_send(1, 4'd2, 2'd2, 2'b01, 4'hF);
      check("t4.busy", busy[1], 2'b10);
      check("t4.req1", req1[1], 1);

      // 5: order queue fills to DEPTH with ord_pop idle
      do_reset();
      for (int i = 0; i < 4; i++) begin
         aw_send(0, 4'(i), 2'd2, 2'b01, 4'hF);
         pulse_done(i % 2 == 0, i % 2 == 1);
      end
      check("t5.full", awr, 2'b00);
      aw_id = 4'd9; aw_valid = 1'b1;
      step(2);
      check("t5.full_hold", awr[0], 0);
      pulse_pop();
      #1;
      check("t5.after_pop", awr[0], 1);
      aw_send(0, 4'd9, 2'd2, 2'b01, 4'hF);
      check("t5.full_again", awr[0], 0);
      pulse_done(1'b1, 1'b0);
      pulse_pop();
      ord_pop = 1'b1;
      aw_send(0, 4'd10, 2'd2, 2'b01, 4'hF);
      ord_pop = 1'b0;
      aw_id = 4'd11;
      #1;
      check("t5.pushpop_count", awr[0], 1);

      // 6: protocol errors and reset mid-burst
      do_reset();
      pulse_done(1'b0, 1'b1);
      check("t6.err_done", perr, 2'b11);
      step(3);
      check("t6.err_sticky", perr[0], 1);
      do_reset();
      pulse_pop();
      check("t6.err_pop", perr[0], 1);
      do_reset();
      aw_send(0, 4'd9, 2'd2, 2'b01, 4'hF);
      aw_send(0, 4'd10, 2'd2, 2'b01, 4'hF);
      reset_n = 1'b0;
      #1;
      check("t6.rst_busy", busy[0], 2'b00);
      check("t6.rst_req", {req1[0], req0[0]}, 2'b00);
      check("t6.rst_ord", ov, 2'b00);
      check("t6.rst_aw_ready", awr, 2'b00);
      step(1);
      reset_n = 1'b1;
      aw_send(0, 4'd4, 2'd2, 2'b01, 4'hF);
      check("t6.slot0_first", busy[0], 2'b01);
      check("t6.req0_first", req0[0], 1);
      check("t6.head_first", os[0], 0);

      step(2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
